// File: rtl/flac_frame_scheduler.sv
// Walks one FLAC encoder across a long sample buffer, one frame of at most FRAME_SIZE samples at a time.
// Output bitstreams are packed back-to-back; each committed frame yields a one-cycle oFrameValid pulse.
module flac_frame_scheduler #(
  parameter int FRAME_SIZE = 32,
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT    = 65535
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic        iStart,
  input  logic [15:0] iTotalSamples,
  input  logic [15:0] iInBase,
  input  logic [15:0] iOutBase,
  input  logic        iAbort,
  output logic        oEncReset,
  output logic [15:0] oNumSamples,
  output logic [15:0] oIAddrStart,
  output logic [15:0] oOAddrStart,
  input  logic        iEncDone,
  input  logic [15:0] iEncOAddr,
  output logic        oFrameValid,
  output logic [15:0] oFrameIdx,
  output logic [15:0] oFrameEnd,
  output logic        oBusy,
  output logic        oJobDone,
  output logic        oError
);

  localparam logic [15:0] FrameLen = 16'(FRAME_SIZE);
  localparam logic [15:0] RstLast  = 16'(RST_CYCLES - 1);
  localparam logic [15:0] RunLast  = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, LAUNCH, ARM, RUN, COMMIT} stateT;

  stateT       state;
  logic [15:0] remaining;
  logic [15:0] frameIdx;
  logic [15:0] cnt;

  function automatic logic [15:0] frameLen(input logic [15:0] rem);
    return (rem > FrameLen) ? FrameLen : rem;
  endfunction

  // oNumSamples/oIAddrStart/oOAddrStart double as the frame length and the input/output pointers.
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      state       <= IDLE;
      remaining   <= '0;
      frameIdx    <= '0;
      cnt         <= '0;
      oEncReset   <= 1'b1;
      oNumSamples <= '0;
      oIAddrStart <= '0;
      oOAddrStart <= '0;
      oFrameValid <= 1'b0;
      oFrameIdx   <= '0;
      oFrameEnd   <= '0;
      oBusy       <= 1'b0;
      oJobDone    <= 1'b0;
      oError      <= 1'b0;
    end else begin
      oFrameValid <= 1'b0;
      oJobDone    <= 1'b0;
      if (state != IDLE && iAbort) begin
        state     <= IDLE;
        oEncReset <= 1'b1;
        oBusy     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (iStart) begin
              oError <= 1'b0;
              if (iTotalSamples == 16'd0) begin
                oJobDone <= 1'b1;
              end else begin
                remaining   <= iTotalSamples;
                oNumSamples <= frameLen(iTotalSamples);
                oIAddrStart <= iInBase;
                oOAddrStart <= iOutBase;
                frameIdx    <= '0;
                cnt         <= '0;
                oBusy       <= 1'b1;
                state       <= LAUNCH;
              end
            end
          end
          LAUNCH: begin
            if (cnt == RstLast) begin
              cnt       <= '0;
              oEncReset <= 1'b0;
              state     <= ARM;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          // A done still high from the previous frame is deliberately not looked at here.
          ARM: begin
            cnt   <= '0;
            state <= RUN;
          end
          RUN: begin
            if (iEncDone) begin
              oFrameValid <= 1'b1;
              oFrameIdx   <= frameIdx;
              oFrameEnd   <= iEncOAddr;
              if (iEncOAddr == 16'hFFFF) oError <= 1'b1;
              else if (remaining == oNumSamples) oJobDone <= 1'b1;
              state <= COMMIT;
            end else if (TIMEOUT != 0 && cnt == RunLast) begin
              oError    <= 1'b1;
              oEncReset <= 1'b1;
              oBusy     <= 1'b0;
              state     <= IDLE;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          COMMIT: begin
            remaining   <= remaining - oNumSamples;
            frameIdx    <= frameIdx + 16'd1;
            oIAddrStart <= oIAddrStart + oNumSamples;
            oOAddrStart <= oFrameEnd + 16'd1;
            oEncReset   <= 1'b1;
            cnt         <= '0;
            if (oFrameEnd == 16'hFFFF || remaining == oNumSamples) begin
              oBusy <= 1'b0;
              state <= IDLE;
            end else begin
              oNumSamples <= frameLen(remaining - oNumSamples);
              state       <= LAUNCH;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_flac_frame_scheduler.sv
// Bench for flac_frame_scheduler: a frame-list model of each job plus a simple encoder model,
// checked on every negative clock edge, with directed jobs covering the corner cases.
module tb_flac_frame_scheduler;

  localparam int FS = 32;

  logic        iClock = 1'b0;
  logic        iReset = 1'b1;
  logic        iStart = 1'b0;
  logic [15:0] iTotalSamples = '0;
  logic [15:0] iInBase = '0;
  logic [15:0] iOutBase = '0;
  logic        iAbort = 1'b0;
  logic        iEncDone = 1'b0;
  logic [15:0] iEncOAddr = '0;
  logic        oEncReset, oFrameValid, oBusy, oJobDone, oError;
  logic [15:0] oNumSamples, oIAddrStart, oOAddrStart, oFrameIdx, oFrameEnd;

  flac_frame_scheduler #(.FRAME_SIZE(FS), .RST_CYCLES(2), .TIMEOUT(100)) dut (
    .iClock(iClock), .iReset(iReset), .iStart(iStart), .iTotalSamples(iTotalSamples),
    .iInBase(iInBase), .iOutBase(iOutBase), .iAbort(iAbort), .oEncReset(oEncReset),
    .oNumSamples(oNumSamples), .oIAddrStart(oIAddrStart), .oOAddrStart(oOAddrStart),
    .iEncDone(iEncDone), .iEncOAddr(iEncOAddr), .oFrameValid(oFrameValid),
    .oFrameIdx(oFrameIdx), .oFrameEnd(oFrameEnd), .oBusy(oBusy), .oJobDone(oJobDone),
    .oError(oError)
  );

  always #5 iClock = ~iClock;

  typedef struct {
    logic [15:0] len, ia, oa, fend, idx;
    bit          last;
  } frameT;

  frameT       expQ[$];
  int          cmpCount = 0, failCount = 0;
  int          frameCnt = 0, jobDoneCnt = 0, bareDoneCnt = 0, armCnt = 0;
  logic [15:0] wordsTab[4];
  int          encFrame = 0, runCnt = 0, encLat = 6;
  bit          encHang = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmpCount++;
    if (act !== exp) begin
      failCount++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Expected frame list of a whole job, straight from the splitting/packing rules.
  task automatic buildModel(input logic [15:0] total, input logic [15:0] inBase, input logic [15:0] outBase);
    logic [15:0] rem, ia, oa;
    frameT f;
    rem = total; ia = inBase; oa = outBase;
    expQ.delete();
    for (int k = 0; rem != 0; k++) begin
      f.len  = (rem > 16'(FS)) ? 16'(FS) : rem;
      f.ia   = ia;
      f.oa   = oa;
      f.fend = oa + wordsTab[k % 4] - 16'd1;
      f.idx  = 16'(k);
      rem    = rem - f.len;
      f.last = (rem == 0);
      expQ.push_back(f);
      ia = ia + f.len;
      oa = f.fend + 16'd1;
    end
  endtask

  // Encoder: done rises encLat cycles after reset release and stays high until a later run clears it.
  always @(negedge iClock) begin
    if (!oBusy) encFrame = 0;
    if (!iReset || oEncReset) begin
      runCnt = 0;
    end else begin
      runCnt++;
      if (runCnt >= 2 && runCnt < encLat) iEncDone = 1'b0;
      if (!encHang && runCnt == encLat) begin
        iEncDone  = 1'b1;
        iEncOAddr = oOAddrStart + wordsTab[encFrame % 4] - 16'd1;
        encFrame++;
      end
    end
  end

  logic  prevRst = 1'b1;
  frameT cf;
  always @(negedge iClock) begin
    if (iReset) begin
      if (prevRst && !oEncReset) begin
        armCnt++;
        if (expQ.size() == 0) begin
          cmpCount++; failCount++;
          $display("FAIL unexpected_arm: numSamples %0d, expected no frame launch", oNumSamples);
        end else begin
          check("arm numSamples", oNumSamples, expQ[0].len);
          check("arm iAddrStart", oIAddrStart, expQ[0].ia);
          check("arm oAddrStart", oOAddrStart, expQ[0].oa);
        end
      end
      if (oFrameValid) begin
        frameCnt++;
        if (expQ.size() == 0) begin
          cmpCount++; failCount++;
          $display("FAIL unexpected_frame: idx %0d, expected no frame", oFrameIdx);
        end else begin
          cf = expQ.pop_front();
          check("frame idx", oFrameIdx, cf.idx);
          check("frame end", oFrameEnd, cf.fend);
          check("commit numSamples", oNumSamples, cf.len);
          check("commit iAddrStart", oIAddrStart, cf.ia);
          check("commit oAddrStart", oOAddrStart, cf.oa);
          check("jobDone with frame", oJobDone, cf.last);
        end
      end else if (oJobDone) begin
        bareDoneCnt++;
      end
      if (oJobDone) jobDoneCnt++;
    end
    prevRst = oEncReset;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge iClock);
  endtask

  task automatic startJob(input logic [15:0] total, input logic [15:0] inB, input logic [15:0] outB);
    iTotalSamples = total; iInBase = inB; iOutBase = outB;
    iStart = 1'b1;
    @(negedge iClock);
    iStart = 1'b0;
  endtask

  task automatic waitLevel(input string name, input logic level, input int budget);
    int n = 0;
    while (oEncReset !== level && n < budget) begin
      @(negedge iClock);
      n++;
    end
    if (oEncReset !== level) begin
      cmpCount++; failCount++;
      $display("FAIL %s: encoder reset still %b after %0d cycles, expected %b", name, oEncReset, n, level);
    end
  endtask

  task automatic runJob(input string name, input logic [15:0] total, input logic [15:0] inB, input logic [15:0] outB);
    int f0, d0, nf, n;
    f0 = frameCnt; d0 = jobDoneCnt; nf = expQ.size(); n = 0;
    startJob(total, inB, outB);
    check({name, " error cleared"}, oError, 1'b0);
    check({name, " busy"}, oBusy, 1'b1);
    while (oBusy && n < 1000) begin
      @(negedge iClock);
      n++;
    end
    if (oBusy) begin
      cmpCount++; failCount++;
      $display("FAIL %s: still busy after %0d cycles, expected idle", name, n);
    end
    tick(2);
    check({name, " frame count"}, frameCnt - f0, nf);
    check({name, " jobDone count"}, jobDoneCnt - d0, 1);
    check({name, " model drained"}, expQ.size(), 0);
  endtask

  initial begin
    int a0, b0, f0, d0;
    wordsTab = '{16'd41, 16'd5, 16'd9, 16'd3};
    #1 iReset = 1'b0;
    tick(2);
    check("reset encReset", oEncReset, 1'b1);
    check("reset numSamples", oNumSamples, 16'd0);
    check("reset iAddrStart", oIAddrStart, 16'd0);
    check("reset oAddrStart", oOAddrStart, 16'd0);
    check("reset frameValid", oFrameValid, 1'b0);
    check("reset frameIdx", oFrameIdx, 16'd0);
    check("reset frameEnd", oFrameEnd, 16'd0);
    check("reset busy", oBusy, 1'b0);
    check("reset jobDone", oJobDone, 1'b0);
    check("reset error", oError, 1'b0);
    iReset = 1'b1;
    tick(2);

    // 36 samples: frames of 32 and 4, first bitstream ends at word 40.
    buildModel(16'd36, 16'd0, 16'd0);
    check("model36 frames", expQ.size(), 2);
    check("model36 f0 len", expQ[0].len, 16'd32);
    check("model36 f0 end", expQ[0].fend, 16'd40);
    check("model36 f1 len", expQ[1].len, 16'd4);
    check("model36 f1 ia", expQ[1].ia, 16'd32);
    check("model36 f1 oa", expQ[1].oa, 16'd41);
    check("model36 f1 last", expQ[1].last, 1'b1);
    runJob("job36", 16'd36, 16'd0, 16'd0);

    // Zero-length job: immediate jobDone, encoder never released.
    a0 = armCnt; b0 = bareDoneCnt; f0 = frameCnt;
    startJob(16'd0, 16'd5, 16'd5);
    check("zero jobDone", oJobDone, 1'b1);
    check("zero busy", oBusy, 1'b0);
    check("zero encReset", oEncReset, 1'b1);
    tick(1);
    check("zero jobDone pulse", oJobDone, 1'b0);
    tick(5);
    check("zero arms", armCnt - a0, 0);
    check("zero frames", frameCnt - f0, 0);
    check("zero bare done", bareDoneCnt - b0, 1);

    // Input address wraps past FFFF.
    wordsTab = '{16'd4, 16'd7, 16'd2, 16'd3};
    buildModel(16'd70, 16'hFFF0, 16'h0100);
    check("model wrap f1 ia", expQ[1].ia, 16'h0010);
    check("model wrap f2 len", expQ[2].len, 16'd6);
    check("model wrap f2 oa", expQ[2].oa, 16'h010B);
    runJob("wrap", 16'd70, 16'hFFF0, 16'h0100);

    // Encoder never finishes: error after 100 RUN cycles.
    encHang = 1;
    buildModel(16'd10, 16'd0, 16'd0);
    f0 = frameCnt;
    startJob(16'd10, 16'd0, 16'd0);
    waitLevel("timeout arm", 1'b0, 20);
    tick(100);
    check("timeout busy before", oBusy, 1'b1);
    check("timeout error before", oError, 1'b0);
    tick(1);
    check("timeout busy", oBusy, 1'b0);
    check("timeout error", oError, 1'b1);
    check("timeout encReset", oEncReset, 1'b1);
    check("timeout frames", frameCnt - f0, 0);
    expQ.delete();
    encHang = 0;
    tick(2);
    buildModel(16'd5, 16'h0020, 16'h0200);
    runJob("after timeout", 16'd5, 16'h0020, 16'h0200);

    // Abort during RUN of frame 1 of 3.
    wordsTab = '{16'd6, 16'd6, 16'd6, 16'd6};
    buildModel(16'd80, 16'h0040, 16'h0300);
    f0 = frameCnt; d0 = jobDoneCnt;
    startJob(16'd80, 16'h0040, 16'h0300);
    waitLevel("abort arm0", 1'b0, 20);
    waitLevel("abort launch1", 1'b1, 40);
    waitLevel("abort arm1", 1'b0, 20);
    tick(2);
    iAbort = 1'b1;
    tick(1);
    iAbort = 1'b0;
    check("abort busy", oBusy, 1'b0);
    check("abort encReset", oEncReset, 1'b1);
    check("abort frameValid", oFrameValid, 1'b0);
    expQ.delete();
    tick(20);
    check("abort frames", frameCnt - f0, 1);
    check("abort jobDone", jobDoneCnt - d0, 0);

    // Asynchronous reset in the middle of RUN.
    buildModel(16'd64, 16'd0, 16'd0);
    f0 = frameCnt; d0 = jobDoneCnt;
    startJob(16'd64, 16'd0, 16'd0);
    waitLevel("areset arm", 1'b0, 20);
    tick(2);
    #2 iReset = 1'b0;
    #1;
    check("areset encReset", oEncReset, 1'b1);
    check("areset busy", oBusy, 1'b0);
    check("areset numSamples", oNumSamples, 16'd0);
    check("areset frameValid", oFrameValid, 1'b0);
    @(negedge iClock);
    expQ.delete();
    iReset = 1'b1;
    tick(20);
    check("areset frames", frameCnt - f0, 0);
    check("areset jobDone", jobDoneCnt - d0, 0);
    check("areset idle", oBusy, 1'b0);

    buildModel(16'd32, 16'h0010, 16'h0020);
    runJob("single", 16'd32, 16'h0010, 16'h0020);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, failCount);
    $finish;
  end

endmodule
